// File: rtl/cache_pkg.sv
// Shared types, defaults and address helpers for the direct-mapped data cache.
package cache_pkg;

  localparam int unsigned DEF_INDEX_BITS  = 6;
  localparam int unsigned DEF_MEM_LATENCY = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned LANES           = 4;
  localparam int unsigned LANE_W          = 8;

  typedef enum logic [2:0] {
    IDLE,
    READ_HIT,
    READ_MISS,
    WRITE,
    DONE
  } cache_state_t;

  // Request captured at acceptance; addr is stored word-aligned.
  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } cache_req_t;

  function automatic logic [WORD_W-1:0] get_index(input logic [WORD_W-1:0] addr,
                                                  input int unsigned       index_bits);
    return (addr >> 2) & ((WORD_W'(1) << index_bits) - WORD_W'(1));
  endfunction

  function automatic logic [WORD_W-1:0] get_tag(input logic [WORD_W-1:0] addr,
                                                input int unsigned       index_bits);
    return addr >> (index_bits + 2);
  endfunction

  function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
    return (v == '1) ? v : v + WORD_W'(1);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Requester-side load/store handshake of the data cache.
interface data_cache_if;
  import cache_pkg::*;

  logic              cache_read;
  logic              cache_write;
  logic [WORD_W-1:0] cache_addr;
  logic [WORD_W-1:0] cache_write_data;
  logic [WORD_W-1:0] cache_load_data;
  logic              cache_ready;

  modport master (
    output cache_read, cache_write, cache_addr, cache_write_data,
    input  cache_load_data, cache_ready
  );

  modport slave (
    input  cache_read, cache_write, cache_addr, cache_write_data,
    output cache_load_data, cache_ready
  );
endinterface

// File: rtl/cache_array.sv
// Valid/tag/data line storage: combinational read by index, single synchronous write port.
module cache_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
  parameter int unsigned TAG_W      = WORD_W - DEF_INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [WORD_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORD_W-1:0]     wr_data
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [WORD_W-1:0] data_mem [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  // Only the valid bits need clearing; stale tag/data are masked by valid.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with fixed-latency memory port.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = DEF_INDEX_BITS,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic               clk,
  input  logic               rst_b,
  data_cache_if.slave        cpu,
  output logic [WORD_W-1:0]  mem_addr,
  output logic [LANE_W-1:0]  mem_data_in  [0:LANES-1],
  output logic               mem_write_en,
  input  logic [LANE_W-1:0]  mem_data_out [0:LANES-1],
  output logic [WORD_W-1:0]  hit_count,
  output logic [WORD_W-1:0]  miss_count
);

  localparam int unsigned TAG_W = WORD_W - INDEX_BITS - 2;
  localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  cache_state_t      state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  cache_req_t        req_q, req_n;
  logic              ready_q, ready_n;
  logic [WORD_W-1:0] load_q, load_n;
  logic [WORD_W-1:0] maddr_n;
  logic [LANE_W-1:0] mdin_n [0:LANES-1];
  logic              we_n;
  logic [WORD_W-1:0] hits_n, misses_n;

  logic [WORD_W-1:0]     in_word_addr;
  logic [INDEX_BITS-1:0] in_index, req_index, rd_index;
  logic [TAG_W-1:0]      in_tag, req_tag;
  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [WORD_W-1:0]     line_data;
  logic                  lookup_hit;
  logic [WORD_W-1:0]     mem_word;

  logic                  arr_we;
  logic [INDEX_BITS-1:0] arr_index;
  logic [TAG_W-1:0]      arr_tag;
  logic [WORD_W-1:0]     arr_data;

  assign in_word_addr = {cpu.cache_addr[WORD_W-1:2], 2'b00};
  assign in_index     = INDEX_BITS'(get_index(cpu.cache_addr, INDEX_BITS));
  assign in_tag       = TAG_W'(get_tag(cpu.cache_addr, INDEX_BITS));
  assign req_index    = INDEX_BITS'(get_index(req_q.addr, INDEX_BITS));
  assign req_tag      = TAG_W'(get_tag(req_q.addr, INDEX_BITS));

  // Lookup uses the live address while idle, the latched one afterwards.
  assign rd_index   = (state_q == IDLE) ? in_index : req_index;
  assign lookup_hit = line_valid && (line_tag == in_tag);
  assign mem_word   = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};

  assign cpu.cache_ready     = ready_q;
  assign cpu.cache_load_data = load_q;

  cache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_index (rd_index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (arr_we),
    .wr_index (arr_index),
    .wr_tag   (arr_tag),
    .wr_data  (arr_data)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    req_n     = req_q;
    ready_n   = 1'b0;
    load_n    = load_q;
    maddr_n   = mem_addr;
    mdin_n    = mem_data_in;
    we_n      = mem_write_en;
    hits_n    = hit_count;
    misses_n  = miss_count;
    arr_we    = 1'b0;
    arr_index = req_index;
    arr_tag   = req_tag;
    arr_data  = req_q.wdata;

    unique case (state_q)
      IDLE: begin
        if (cpu.cache_write) begin
          state_n     = WRITE;
          cnt_n       = '0;
          req_n.addr  = in_word_addr;
          req_n.wdata = cpu.cache_write_data;
          maddr_n     = in_word_addr;
          we_n        = 1'b1;
          for (int i = 0; i < int'(LANES); i++) begin
            mdin_n[i] = cpu.cache_write_data[LANE_W*i +: LANE_W];
          end
          // Write hit refreshes the line now; a write miss never allocates.
          if (lookup_hit) begin
            arr_we    = 1'b1;
            arr_index = in_index;
            arr_tag   = in_tag;
            arr_data  = cpu.cache_write_data;
          end
        end else if (cpu.cache_read) begin
          cnt_n      = '0;
          req_n.addr = in_word_addr;
          if (lookup_hit) begin
            state_n = READ_HIT;
          end else begin
            state_n = READ_MISS;
            maddr_n = in_word_addr;
          end
        end
      end

      READ_HIT: begin
        load_n  = line_data;
        ready_n = 1'b1;
        hits_n  = sat_inc(hit_count);
        state_n = DONE;
      end

      READ_MISS: begin
        if (cnt_q == CNT_LAST) begin
          arr_we   = 1'b1;
          arr_data = mem_word;
          load_n   = mem_word;
          ready_n  = 1'b1;
          misses_n = sat_inc(miss_count);
          state_n  = DONE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      WRITE: begin
        if (cnt_q == CNT_LAST) begin
          we_n    = 1'b0;
          ready_n = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      ready_q      <= 1'b0;
      load_q       <= '0;
      mem_addr     <= '0;
      mem_data_in  <= '{default: '0};
      mem_write_en <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      req_q        <= req_n;
      ready_q      <= ready_n;
      load_q       <= load_n;
      mem_addr     <= maddr_n;
      mem_data_in  <= mdin_n;
      mem_write_en <= we_n;
      hit_count    <= hits_n;
      miss_count   <= misses_n;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a driver issues accesses against a behavioural cache/memory
// model, a monitor checks every ready pulse, and a memory responder checks write-through traffic.
module tb_data_cache;

  localparam int unsigned ML    = 4;
  localparam int unsigned LINES = 64;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_in  [0:3];
  logic        mem_write_en;
  logic [7:0]  mem_data_out [0:3];
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  data_cache_if cpu ();

  data_cache dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .cpu          (cpu),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  typedef struct {
    logic [31:0] data;
    int unsigned issue;
    int unsigned lat;
    int unsigned hits;
    int unsigned misses;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t sbq [$];
  wr_t  wq  [$];

  // Model: memory contents as the requester expects them, and which tag each line holds.
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] dev_mem [logic [29:0]];
  bit          line_v  [LINES];
  logic [23:0] line_t  [LINES];
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;
  logic [31:0] last_load  = '0;
  int unsigned we_run     = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w[13:0], w[17:0]} ^ 32'hA5C3_0F96;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] dev_rd(input logic [29:0] w);
    return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
  endfunction

  // Predict the outcome of one accepted access and queue it for the monitor.
  task automatic model_issue(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, input int unsigned issue);
    exp_t        e;
    logic [29:0] w   = a[31:2];
    int unsigned idx = int'(a[7:2]);
    logic [23:0] tag = a[31:8];
    e.issue = issue;
    if (wr) begin
      wq.push_back('{addr: {w, 2'b00}, data: d});
      ref_mem[w] = d;
      e.lat = ML + 1;
    end else if (rd) begin
      if (line_v[idx] && line_t[idx] == tag) begin
        exp_hits++;
        e.lat = 2;
      end else begin
        exp_misses++;
        line_v[idx] = 1'b1;
        line_t[idx] = tag;
        e.lat = ML + 1;
      end
      last_load = ref_rd(w);
    end
    e.data   = last_load;
    e.hits   = exp_hits;
    e.misses = exp_misses;
    sbq.push_back(e);
  endtask

  // Response monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_b && cpu.cache_ready) begin
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ready: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        check("ready_latency", 32'(cyc - e.issue), 32'(e.lat));
        check("load_data", cpu.cache_load_data, e.data);
        check("hit_count", hit_count, 32'(e.hits));
        check("miss_count", miss_count, 32'(e.misses));
      end
    end
  end

  // Memory responder: commits completed writes and presents read data.
  always @(negedge clk) begin : memory
    wr_t         x;
    logic [31:0] word;
    if (!rst_b) begin
      we_run = 0;
    end else if (mem_write_en) begin
      we_run++;
    end else if (we_run != 0) begin
      if (wq.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_mem_write: got addr %h expected none", mem_addr);
      end else begin
        x = wq.pop_front();
        check("mem_write_len", 32'(we_run), 32'(ML));
        check("mem_write_addr", mem_addr, x.addr);
        check("mem_write_lanes",
              {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]}, x.data);
      end
      dev_mem[mem_addr[31:2]] = {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]};
      we_run = 0;
    end
    word = dev_rd(mem_addr[31:2]);
    for (int i = 0; i < 4; i++) mem_data_out[i] = word[8*i +: 8];
  end

  // One access; reps > 1 keeps the request high through DONE so it is re-accepted.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input int reps);
    bit ok;
    bit scr = (reps == 1) && ($urandom_range(0, 3) == 0);
    cpu.cache_read       = rd;
    cpu.cache_write      = wr;
    cpu.cache_addr       = a;
    cpu.cache_write_data = d;
    for (int r = 0; r < reps; r++) begin
      model_issue(rd, wr, a, d, (r == 0) ? cyc : cyc + 1);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (k == 0 && scr) begin
          cpu.cache_addr       = $urandom();
          cpu.cache_write_data = $urandom();
          cpu.cache_read       = 1'b0;
          cpu.cache_write      = 1'b0;
        end
        if (cpu.cache_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_checks++;
        $display("FAIL ready_timeout: got no ready expected ready for addr %h", a);
        break;
      end
    end
    cpu.cache_read  = 1'b0;
    cpu.cache_write = 1'b0;
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;
    rst_b                = 1'b0;
    cpu.cache_read       = 1'b0;
    cpu.cache_write      = 1'b0;
    cpu.cache_addr       = '0;
    cpu.cache_write_data = '0;
    ref_mem[30'h10]      = 32'h4433_2211;
    dev_mem[30'h10]      = 32'h4433_2211;

    #1;
    check("rst_ready", 32'(cpu.cache_ready), 32'd0);
    check("rst_load_data", cpu.cache_load_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data_in", {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]}, 32'd0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'd0);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // Reset in the middle of a write aborts it without a ready pulse.
    cpu.cache_write      = 1'b1;
    cpu.cache_addr       = 32'h0000_0200;
    cpu.cache_write_data = 32'h55AA_55AA;
    repeat (3) @(negedge clk);
    check("abort_we_active", 32'(mem_write_en), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    check("abort_we_dropped", 32'(mem_write_en), 32'd0);
    check("abort_ready", 32'(cpu.cache_ready), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_data_in", {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]}, 32'd0);
    cpu.cache_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    // Directed scenarios.
    access(1, 0, 32'h0000_0040, 32'h0, 1);
    access(1, 0, 32'h0000_0040, 32'h0, 1);
    access(0, 1, 32'h0000_0040, 32'hDEAD_BEEF, 1);
    access(1, 0, 32'h0000_0040, 32'h0, 1);
    access(0, 1, 32'h0000_0080, 32'hCAFE_F00D, 1);
    access(1, 0, 32'h0000_0080, 32'h0, 1);
    access(1, 0, 32'h0000_0040, 32'h0, 1);
    access(1, 0, 32'h0000_0140, 32'h0, 1);
    access(1, 0, 32'h0000_0040, 32'h0, 1);
    access(1, 1, 32'h0000_0040, 32'h1234_5678, 2);
    access(1, 0, 32'h0000_0040, 32'h0, 1);

    // Randomized traffic over a few tags and lines to mix hits, misses and conflicts.
    for (int n = 0; n < 200; n++) begin
      a   = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      access(sel < 5, sel >= 5, a, $urandom(), ($urandom_range(0, 9) == 0) ? 2 : 1);
    end

    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0 && wq.size() == 0) break;
      @(negedge clk);
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    check("writes_drained", 32'(wq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
